centroid_stream_average: RTL and testbench
==========================================

# centroid_stream_average

Streaming, parametrised successor to the combinational selective averager used in the k-means datapath. Accepts one tagged point per cycle over a valid/ready handshake and accumulates per-cluster coordinate sums and counts for `K` clusters. On the last point of a batch, divides each cluster's sums by its count with a shared sequential divider and emits one average per cluster, in cluster order, over a second valid/ready handshake. It sits between the point-assignment stage (which produces the cluster tag) and the centroid register file.

## Interface
Parameters:
- `W`, default 32: signed two's-complement fixed-point coordinate width.
- `K`, default 4: number of clusters, at least 2.
- `CW`, default 16: per-cluster count width.
- Derived `S = W + CW`: sum width. Derived `IW = clog2(K)`: tag width.

Ports:
- `clk`, in, 1: clock. One clock; all state on the rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `io_in_valid`, in, 1 / `io_in_ready`, out, 1: input handshake.
- `io_in_x`, `io_in_y`, in, W: point coordinates (signed).
- `io_in_cent`, in, 32: cluster tag.
- `io_in_last`, in, 1: marks the final point of a batch.
- `io_out_valid`, out, 1 / `io_out_ready`, in, 1: output handshake.
- `io_out_cent`, out, IW: cluster index of the current result.
- `io_out_x`, `io_out_y`, out, W: average, truncated toward zero.
- `io_out_count`, out, CW: number of points accumulated for this cluster.
- `io_out_empty`, out, 1: count is 0, so the averages are 0.
- `io_overflow`, out, 1: sticky flag, set when a point is dropped on count saturation; cleared when a batch completes and on reset.

## Operation
States: `ACCUM`, `DIVIDE`, `OUTPUT`. Reset enters `ACCUM` and zeroes all sums, counts, output registers, `io_out_valid` and `io_overflow`.

**ACCUM**
- `io_in_ready` = 1.
- On an input handshake with `io_in_cent < K` and `count[c] < 2^CW-1`: `sumx[c] += sext(x)`, `sumy[c] += sext(y)`, `count[c] += 1`.
- Tag `>= K`: the point is silently dropped and no flag is raised.
- Saturated count: the point is dropped and `io_overflow` is set.
- `io_in_last` on any accepted beat, including a dropped one: go to `DIVIDE` with index `i = 0`.

**DIVIDE**
- `io_in_ready` = 0.
- If `count[i] == 0`: load the output with x = 0, y = 0, empty = 1, and go to `OUTPUT` next cycle.
- Otherwise start two `seq_divider` instances (x and y) on `|sum|` / `count`.
- Each quotient takes its sign from its sum and is truncated toward zero.
- The quotient always fits in W bits.
- When both dividers finish, register the results and go to `OUTPUT`.

**OUTPUT**
- `io_out_valid` = 1. All `io_out_*` signals are held stable until `io_out_ready`.
- On the handshake: if `i < K-1`, set `i += 1` and return to `DIVIDE`.
- Otherwise clear all sums and counts, clear `io_overflow`, and return to `ACCUM`.

**Boundary cases**
- Simultaneous `io_in_last` and a saturating point: the drop rule applies, then the state transition.
- Reset in any state aborts the batch, discards pending outputs, and takes effect at the next edge.

## Timing
- Accumulation: an accepted point is visible in the sums on the next edge. Throughput is 1 point per cycle.
- The divide for cluster 0 starts in the cycle after the last-beat handshake. The divide for cluster `i > 0` starts in the cycle after the handshake for `i-1`.
- `io_out_valid` rises `S+1` cycles after the divide starts for a non-empty cluster, and 1 cycle after for an empty one.
- `seq_divider` is a restoring divider: 1 load cycle plus `S` iteration cycles, one quotient bit per cycle.
- `io_in_ready` returns high in the cycle after the final output handshake.
- No combinational path from `io_out_ready` to `io_out_*` or from `io_in_valid` to `io_in_ready`.

## Structure
- Shared package holds:
  - state encoding constants `ST_ACCUM`, `ST_DIVIDE`, `ST_OUTPUT`;
  - the sum-width helper `S = W + CW`;
  - the divider-latency constant `S + 1`.
- One sub-module: `seq_divider` (unsigned, S-bit dividend, CW-bit divisor).
  - Ports: `start`, `done`, `busy`.
  - Instantiated twice, once for x and once for y.
- Sums and counts are register arrays indexed by tag. There is no RAM.

## Test plan
All scenarios use W=32, K=4, CW=16 (S=48).
1. **Basic average.** Points (1,2), (3,4), (5,6) with tag 1, `io_in_last` on the third → outputs in order:
   - cent 0: (0,0), count 0, empty;
   - cent 1: (3,4), count 3;
   - cent 2 and cent 3: empty.
2. **Signed truncation.** Points (-7,5), (-2,0) with tag 0 → cent 0: (-4,2), count 2, since -9/2 truncates to -4.
3. **Latency and backpressure.**
   - Single point (10,-10) with tag 0 and last accepted at edge n → `io_out_valid` first high in cycle n+50 with (10,-10).
   - Hold `io_out_ready` low for 10 cycles → outputs stable and `io_in_ready` = 0 throughout.
4. **Out-of-range tag.** Tag 4 (x=100) followed by tag 7 with last → that point is dropped, the batch still ends, all four clusters are empty, `io_overflow` = 0.
5. **Saturation.** 65536 points with tag 2, value (1,1):
   - the last point is dropped and `io_overflow` = 1;
   - cent 2: (1,1), count 65535;
   - `io_overflow` is 0 after the final handshake.
6. **Reset mid-operation.**
   - Assert `reset` for 1 cycle during DIVIDE of cluster 1 → next cycle `io_out_valid` = 0 and `io_in_ready` = 1.
   - A following batch of (4,4) with tag 3 → cent 3: (4,4), count 1, with no residue from the aborted batch.

Source files
------------

// File: rtl/centroid_stream_average_pkg.sv
// Shared definitions for the centroid stream averager.
// Contents:
//   state_e      - controller state encoding (ST_ACCUM, ST_DIVIDE, ST_OUTPUT)
//   sum_width    - width of a per-cluster coordinate sum (W + CW)
//   div_latency  - cycles taken by the sequential divider (1 load + S iterations)
package centroid_stream_average_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    function automatic int sum_width(input int w, input int cw);
        return w + cw;
    endfunction

    function automatic int div_latency(input int s);
        return s + 1;
    endfunction

endpackage

// File: rtl/centroid_stream_average_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start_i       - begin a division (ignored while busy)
//   dividend_i    - S-bit unsigned dividend
//   divisor_i     - CW-bit unsigned divisor, must be non-zero
//   quotient_o    - low QW bits of the quotient, valid while done_o is high
//   busy_o        - division in progress
//   done_o        - one-cycle pulse when the quotient is ready
module seq_divider
    import centroid_stream_average_pkg::*;
#(
    parameter int S  = 48,
    parameter int CW = 16,
    parameter int QW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [S-1:0]  dividend_i,
    input  logic [CW-1:0] divisor_i,
    output logic [QW-1:0] quotient_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int LAT  = div_latency(S);
    localparam int CNTW = $clog2(LAT + 1);

    logic [S-1:0]    quo_q;
    logic [CW-1:0]   rem_q;
    logic [CW-1:0]   div_q;
    logic [CNTW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;

    // The partial remainder is always below the divisor, so after shifting in
    // the next dividend bit it needs one extra bit; the top bit of the trial
    // difference is then the borrow.
    logic [CW:0] rem_sh;
    logic [CW:0] diff;

    assign rem_sh = {rem_q, quo_q[S-1]};
    assign diff   = rem_sh - {1'b0, div_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: every sequential update uses <= so all registers see the
            // values from before this edge, regardless of statement order.
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                quo_q  <= dividend_i;
                rem_q  <= '0;
                div_q  <= divisor_i;
                cnt_q  <= CNTW'(LAT - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (!diff[CW]) begin
                    rem_q <= diff[CW-1:0];
                    quo_q <= {quo_q[S-2:0], 1'b1};
                end else begin
                    rem_q <= rem_sh[CW-1:0];
                    quo_q <= {quo_q[S-2:0], 1'b0};
                end
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo_q[QW-1:0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/centroid_stream_average.sv
// Streaming per-cluster centroid averager.
// Accumulates tagged points into K cluster sums/counts, then on the last point
// of a batch divides each sum by its count and emits one average per cluster.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   io_in_valid / io_in_ready  - input handshake (ready only while accumulating)
//   io_in_x, io_in_y           - signed point coordinates
//   io_in_cent                 - cluster tag; tags >= K are dropped silently
//   io_in_last                 - final point of the batch
//   io_out_valid / io_out_ready- output handshake, one beat per cluster
//   io_out_cent                - cluster index of the current result
//   io_out_x, io_out_y         - averages truncated toward zero
//   io_out_count, io_out_empty - points in the cluster, and count == 0
//   io_overflow                - sticky: a point was dropped on count saturation
module centroid_stream_average
    import centroid_stream_average_pkg::*;
#(
    parameter  int W  = 32,
    parameter  int K  = 4,
    parameter  int CW = 16,
    localparam int S  = sum_width(W, CW),
    localparam int IW = $clog2(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic signed [W-1:0]  io_in_x,
    input  logic signed [W-1:0]  io_in_y,
    input  logic [31:0]          io_in_cent,
    input  logic                 io_in_last,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [IW-1:0]        io_out_cent,
    output logic signed [W-1:0]  io_out_x,
    output logic signed [W-1:0]  io_out_y,
    output logic [CW-1:0]        io_out_count,
    output logic                 io_out_empty,
    output logic                 io_overflow
);

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic signed [S-1:0]   sumx_q [K];
    logic signed [S-1:0]   sumy_q [K];
    logic [CW-1:0]         count_q [K];
    logic                  overflow_q;
    logic signed [W-1:0]   out_x_q, out_y_q;
    logic [CW-1:0]         out_count_q;
    logic                  out_empty_q;

    // Input side
    logic          in_hs, tag_ok, tag_sat, acc_en, set_ovf;
    logic [IW-1:0] in_tag;

    assign io_in_ready = (state_q == ST_ACCUM);
    assign in_hs       = io_in_valid && io_in_ready;
    assign in_tag      = io_in_cent[IW-1:0];
    assign tag_ok      = (io_in_cent < K);
    assign tag_sat     = (count_q[in_tag] == '1);
    assign acc_en      = in_hs && tag_ok && !tag_sat;
    assign set_ovf     = in_hs && tag_ok && tag_sat;

    // Divide side: magnitudes go through the unsigned divider, the sign of
    // each sum is reapplied to its quotient, which truncates toward zero.
    logic signed [S-1:0] sumx_sel, sumy_sel;
    logic [CW-1:0]       count_sel;
    logic [S-1:0]        abs_x, abs_y;
    logic [W-1:0]        quo_x, quo_y;
    logic signed [W-1:0] res_x, res_y;
    logic                busy_x, busy_y, done_x, done_y, div_start;

    assign sumx_sel  = sumx_q[idx_q];
    assign sumy_sel  = sumy_q[idx_q];
    assign count_sel = count_q[idx_q];
    assign abs_x     = sumx_sel[S-1] ? -sumx_sel : sumx_sel;
    assign abs_y     = sumy_sel[S-1] ? -sumy_sel : sumy_sel;
    assign res_x     = sumx_sel[S-1] ? -quo_x : quo_x;
    assign res_y     = sumy_sel[S-1] ? -quo_y : quo_y;

    seq_divider #(.S(S), .CW(CW), .QW(W)) u_div_x (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (abs_x),
        .divisor_i  (count_sel),
        .quotient_o (quo_x),
        .busy_o     (busy_x),
        .done_o     (done_x)
    );

    seq_divider #(.S(S), .CW(CW), .QW(W)) u_div_y (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (abs_y),
        .divisor_i  (count_sel),
        .quotient_o (quo_y),
        .busy_o     (busy_y),
        .done_o     (done_y)
    );

    // Controller
    logic load_empty, load_div, clear_batch;

    always_comb begin
        // NOTE: every output gets a default first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        div_start   = 1'b0;
        load_empty  = 1'b0;
        load_div    = 1'b0;
        clear_batch = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (in_hs && io_in_last) begin
                    state_d = ST_DIVIDE;
                    idx_d   = '0;
                end
            end
            ST_DIVIDE: begin
                if (count_sel == '0) begin
                    load_empty = 1'b1;
                    state_d    = ST_OUTPUT;
                end else if (done_x && done_y) begin
                    load_div = 1'b1;
                    state_d  = ST_OUTPUT;
                end else if (!(busy_x || busy_y)) begin
                    div_start = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (io_out_ready) begin
                    if (idx_q == IW'(K - 1)) begin
                        clear_batch = 1'b1;
                        state_d     = ST_ACCUM;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DIVIDE;
                    end
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_count_q <= '0;
            out_empty_q <= 1'b0;
            // NOTE: the cluster arrays are plain registers, not RAM, and must
            // be cleared so an aborted batch leaves no residue.
            for (int c = 0; c < K; c++) begin
                sumx_q[c]  <= '0;
                sumy_q[c]  <= '0;
                count_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (acc_en) begin
                sumx_q[in_tag]  <= sumx_q[in_tag] + {{CW{io_in_x[W-1]}}, io_in_x};
                sumy_q[in_tag]  <= sumy_q[in_tag] + {{CW{io_in_y[W-1]}}, io_in_y};
                count_q[in_tag] <= count_q[in_tag] + 1'b1;
            end
            if (set_ovf) begin
                overflow_q <= 1'b1;
            end
            if (load_empty) begin
                out_x_q     <= '0;
                out_y_q     <= '0;
                out_count_q <= '0;
                out_empty_q <= 1'b1;
            end
            if (load_div) begin
                out_x_q     <= res_x;
                out_y_q     <= res_y;
                out_count_q <= count_sel;
                out_empty_q <= 1'b0;
            end
            if (clear_batch) begin
                overflow_q <= 1'b0;
                for (int c = 0; c < K; c++) begin
                    sumx_q[c]  <= '0;
                    sumy_q[c]  <= '0;
                    count_q[c] <= '0;
                end
            end
        end
    end

    assign io_out_valid = (state_q == ST_OUTPUT);
    assign io_out_cent  = idx_q;
    assign io_out_x     = out_x_q;
    assign io_out_y     = out_y_q;
    assign io_out_count = out_count_q;
    assign io_out_empty = out_empty_q;
    assign io_overflow  = overflow_q;

endmodule

// File: tb/tb_centroid_stream_average.sv
// Directed bench for centroid_stream_average with W=32, K=4, CW=16.
module tb_centroid_stream_average;

    logic               clk = 1'b0;
    logic               reset;
    logic               io_in_valid;
    logic               io_in_ready;
    logic signed [31:0] io_in_x, io_in_y;
    logic [31:0]        io_in_cent;
    logic               io_in_last;
    logic               io_out_valid;
    logic               io_out_ready;
    logic [1:0]         io_out_cent;
    logic signed [31:0] io_out_x, io_out_y;
    logic [15:0]        io_out_count;
    logic               io_out_empty;
    logic               io_overflow;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    centroid_stream_average #(.W(32), .K(4), .CW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_x      (io_in_x),
        .io_in_y      (io_in_y),
        .io_in_cent   (io_in_cent),
        .io_in_last   (io_in_last),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_cent  (io_out_cent),
        .io_out_x     (io_out_x),
        .io_out_y     (io_out_y),
        .io_out_count (io_out_count),
        .io_out_empty (io_out_empty),
        .io_overflow  (io_overflow)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat; io_in_ready is checked where the handshake is expected.
    task automatic send_point(input int x, input int y, input int tag, input bit last);
        check("in_ready before beat", io_in_ready, 1);
        io_in_valid = 1'b1;
        io_in_x     = x;
        io_in_y     = y;
        io_in_cent  = tag;
        io_in_last  = last;
        step();
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
    endtask

    task automatic expect_out(input int cent, input int ex, input int ey,
                              input int ecount, input bit eempty);
        int n = 0;
        while (io_out_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check($sformatf("c%0d out_valid", cent), io_out_valid, 1);
        check($sformatf("c%0d out_cent", cent), io_out_cent, cent);
        check($sformatf("c%0d out_x", cent), io_out_x, ex);
        check($sformatf("c%0d out_y", cent), io_out_y, ey);
        check($sformatf("c%0d out_count", cent), io_out_count, ecount);
        check($sformatf("c%0d out_empty", cent), io_out_empty, eempty);
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_x      = 0;
        io_in_y      = 0;
        io_in_cent   = 0;
        io_in_last   = 1'b0;
        io_out_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        check("reset out_valid", io_out_valid, 0);
        check("reset in_ready", io_in_ready, 1);
        check("reset overflow", io_overflow, 0);

        // 1. Basic average
        send_point(1, 2, 1, 1'b0);
        send_point(3, 4, 1, 1'b0);
        send_point(5, 6, 1, 1'b1);
        check("t1 in_ready low after last", io_in_ready, 0);
        expect_out(0, 0, 0, 0, 1'b1);
        expect_out(1, 3, 4, 3, 1'b0);
        expect_out(2, 0, 0, 0, 1'b1);
        expect_out(3, 0, 0, 0, 1'b1);
        check("t1 in_ready after final hs", io_in_ready, 1);

        // 2. Signed truncation: -9/2 -> -4, 5/2 -> 2
        send_point(-7, 5, 0, 1'b0);
        send_point(-2, 0, 0, 1'b1);
        expect_out(0, -4, 2, 2, 1'b0);
        for (int c = 1; c < 4; c++) expect_out(c, 0, 0, 0, 1'b1);

        // 3. Latency and backpressure
        send_point(10, -10, 0, 1'b1);
        lat = 0;
        while (io_out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        check("t3 latency to out_valid", lat, 50);
        for (int i = 0; i < 10; i++) begin
            check("t3 hold out_valid", io_out_valid, 1);
            check("t3 hold out_x", io_out_x, 10);
            check("t3 hold out_y", io_out_y, -10);
            check("t3 hold in_ready", io_in_ready, 0);
            step();
        end
        expect_out(0, 10, -10, 1, 1'b0);
        for (int c = 1; c < 4; c++) expect_out(c, 0, 0, 0, 1'b1);

        // 4. Out-of-range tags
        send_point(100, 0, 4, 1'b0);
        send_point(0, 0, 7, 1'b1);
        check("t4 overflow", io_overflow, 0);
        for (int c = 0; c < 4; c++) expect_out(c, 0, 0, 0, 1'b1);
        check("t4 overflow after batch", io_overflow, 0);

        // 5. Saturation: 65536 points, the last one is dropped
        io_in_valid = 1'b1;
        io_in_x     = 1;
        io_in_y     = 1;
        io_in_cent  = 2;
        for (int i = 0; i < 65536; i++) begin
            io_in_last = (i == 65535);
            step();
        end
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        check("t5 overflow set", io_overflow, 1);
        expect_out(0, 0, 0, 0, 1'b1);
        expect_out(1, 0, 0, 0, 1'b1);
        expect_out(2, 1, 1, 65535, 1'b0);
        check("t5 overflow before final hs", io_overflow, 1);
        expect_out(3, 0, 0, 0, 1'b1);
        check("t5 overflow cleared", io_overflow, 0);

        // 6. Reset during the divide of cluster 1
        send_point(7, 7, 0, 1'b0);
        send_point(9, 9, 1, 1'b1);
        expect_out(0, 7, 7, 1, 1'b0);
        repeat (5) step();
        check("t6 still dividing", io_out_valid, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6 out_valid after reset", io_out_valid, 0);
        check("t6 in_ready after reset", io_in_ready, 1);
        repeat (60) step();
        check("t6 no stray output", io_out_valid, 0);
        send_point(4, 4, 3, 1'b1);
        for (int c = 0; c < 3; c++) expect_out(c, 0, 0, 0, 1'b1);
        expect_out(3, 4, 4, 1, 1'b0);
        check("t6 in_ready after batch", io_in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
